// File: rtl/ub_pkg.sv
// Shared constants and type definitions for the unified-buffer bank scheduler.
package ub_pkg;

    localparam int UB_ADDR_W = 8;
    localparam int UB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWAP
    } ub_state_t;

    typedef enum logic {
        REQ_COMPUTE,
        REQ_DMA
    } ub_req_id_t;

endpackage

// File: rtl/ub_rr_arb2.sv
// Two-way round-robin arbiter (compute vs DMA) with a registered priority pointer.
module ub_rr_arb2
    import ub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_compute,
    input  logic req_dma,
    output logic gnt_compute,
    output logic gnt_dma
);

    ub_req_id_t prio;
    logic       contended;

    assign contended   = en && req_compute && req_dma;
    assign gnt_compute = en && req_compute && (!req_dma || (prio == REQ_COMPUTE));
    assign gnt_dma     = en && req_dma && (!req_compute || (prio == REQ_DMA));

    // Priority only moves on a contended grant, handing it to the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= REQ_COMPUTE;
        end else if (contended) begin
            prio <= gnt_compute ? REQ_DMA : REQ_COMPUTE;
        end
    end

endmodule

// File: rtl/ub_bank_scheduler.sv
// Unified-buffer bank scheduler: arbitrates the UB read/write ports and owns the ping-pong swap.
// Define UB_SCHED_STATS_EN to add saturating per-port conflict counters.
module ub_bank_scheduler
    import ub_pkg::*;
#(
    parameter int ADDR_W = UB_ADDR_W,
    parameter int DATA_W = UB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sys_rd_req,
    input  logic [ADDR_W-1:0] sys_rd_addr,
    output logic              sys_rd_gnt,
    output logic              sys_rd_vld,
    input  logic              dma_rd_req,
    input  logic [ADDR_W:0]   dma_rd_addr,
    output logic              dma_rd_gnt,
    output logic              dma_rd_vld,
    output logic [DATA_W-1:0] rd_data,
    input  logic              vpu_wr_req,
    input  logic [ADDR_W-1:0] vpu_wr_addr,
    input  logic [DATA_W-1:0] vpu_wr_data,
    output logic              vpu_wr_gnt,
    input  logic              dma_wr_req,
    input  logic [ADDR_W:0]   dma_wr_addr,
    input  logic [DATA_W-1:0] dma_wr_data,
    output logic              dma_wr_gnt,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              ub_buf_sel,
    output logic              busy,
`ifdef UB_SCHED_STATS_EN
    output logic [15:0]       rd_conflict_cnt,
    output logic [15:0]       wr_conflict_cnt,
`endif
    output logic              ub_rd_en,
    output logic [ADDR_W:0]   ub_rd_addr,
    input  logic [DATA_W-1:0] ub_rd_data,
    output logic              ub_wr_en,
    output logic [ADDR_W:0]   ub_wr_addr,
    output logic [DATA_W-1:0] ub_wr_data
);

    ub_state_t state;
    ub_state_t state_nxt;
    logic      grant_en;
    logic      read_pending;

    // Grants are gated by reset so the outputs read zero while reset is held.
    assign grant_en     = (state == IDLE) && !rst;
    assign read_pending = sys_rd_vld || dma_rd_vld;
    assign busy         = (state != IDLE) || read_pending;
    assign rd_data      = ub_rd_data;

    ub_rr_arb2 u_rd_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (grant_en),
        .req_compute (sys_rd_req),
        .req_dma     (dma_rd_req),
        .gnt_compute (sys_rd_gnt),
        .gnt_dma     (dma_rd_gnt)
    );

    ub_rr_arb2 u_wr_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (grant_en),
        .req_compute (vpu_wr_req),
        .req_dma     (dma_wr_req),
        .gnt_compute (vpu_wr_gnt),
        .gnt_dma     (dma_wr_gnt)
    );

    // Compute reads use the current bank; VPU writes target the opposite one.
    always_comb begin
        ub_rd_en   = sys_rd_gnt || dma_rd_gnt;
        ub_rd_addr = '0;
        if (sys_rd_gnt) begin
            ub_rd_addr = {ub_buf_sel, sys_rd_addr};
        end else if (dma_rd_gnt) begin
            ub_rd_addr = dma_rd_addr;
        end

        ub_wr_en   = vpu_wr_gnt || dma_wr_gnt;
        ub_wr_addr = '0;
        ub_wr_data = '0;
        if (vpu_wr_gnt) begin
            ub_wr_addr = {~ub_buf_sel, vpu_wr_addr};
            ub_wr_data = vpu_wr_data;
        end else if (dma_wr_gnt) begin
            ub_wr_addr = dma_wr_addr;
            ub_wr_data = dma_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ub_buf_sel <= 1'b0;
            sys_rd_vld <= 1'b0;
            dma_rd_vld <= 1'b0;
        end else begin
            state      <= state_nxt;
            sys_rd_vld <= sys_rd_gnt;
            dma_rd_vld <= dma_rd_gnt;
            if (state == SWAP) begin
                ub_buf_sel <= ~ub_buf_sel;
            end
        end
    end

    // DRAIN waits for the in-flight read to land before the bank flips.
    always_comb begin
        state_nxt = state;
        swap_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (swap_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!read_pending) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                swap_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UB_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_conflict_cnt <= '0;
            wr_conflict_cnt <= '0;
        end else begin
            if (sys_rd_req && dma_rd_req && (rd_conflict_cnt != 16'hFFFF)) begin
                rd_conflict_cnt <= rd_conflict_cnt + 16'd1;
            end
            if (vpu_wr_req && dma_wr_req && (wr_conflict_cnt != 16'hFFFF)) begin
                wr_conflict_cnt <= wr_conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ub_bank_scheduler.sv
// Self-checking bench for ub_bank_scheduler: directed scenarios plus randomized traffic vs a reference model.
module tb_ub_bank_scheduler;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sys_rd_req, dma_rd_req, vpu_wr_req, dma_wr_req, swap_req;
    logic [ADDR_W-1:0] sys_rd_addr, vpu_wr_addr;
    logic [ADDR_W:0]   dma_rd_addr, dma_wr_addr;
    logic [DATA_W-1:0] vpu_wr_data, dma_wr_data, ub_rd_data;
    logic              sys_rd_gnt, sys_rd_vld, dma_rd_gnt, dma_rd_vld;
    logic              vpu_wr_gnt, dma_wr_gnt, swap_ack, ub_buf_sel, busy;
    logic [DATA_W-1:0] rd_data, ub_wr_data;
    logic              ub_rd_en, ub_wr_en;
    logic [ADDR_W:0]   ub_rd_addr, ub_wr_addr;
`ifdef UB_SCHED_STATS_EN
    logic [15:0]       rd_conflict_cnt, wr_conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: bank select, swap progress (0 serving, 1 draining, 2 flipping),
    // which requester gets the next contended grant, and which read is in flight.
    bit          m_buf_sel, m_rd_fav_dma, m_wr_fav_dma, m_sys_inflight, m_dma_inflight;
    int          m_phase;
    int          m_rd_cnt, m_wr_cnt;
    bit          e_sys_gnt, e_dma_rd_gnt, e_vpu_gnt, e_dma_wr_gnt;
    logic [8:0]  e_rd_addr, e_wr_addr;
    logic [63:0] e_wr_data;

    always #5 clk = ~clk;

    ub_bank_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .sys_rd_req  (sys_rd_req),
        .sys_rd_addr (sys_rd_addr),
        .sys_rd_gnt  (sys_rd_gnt),
        .sys_rd_vld  (sys_rd_vld),
        .dma_rd_req  (dma_rd_req),
        .dma_rd_addr (dma_rd_addr),
        .dma_rd_gnt  (dma_rd_gnt),
        .dma_rd_vld  (dma_rd_vld),
        .rd_data     (rd_data),
        .vpu_wr_req  (vpu_wr_req),
        .vpu_wr_addr (vpu_wr_addr),
        .vpu_wr_data (vpu_wr_data),
        .vpu_wr_gnt  (vpu_wr_gnt),
        .dma_wr_req  (dma_wr_req),
        .dma_wr_addr (dma_wr_addr),
        .dma_wr_data (dma_wr_data),
        .dma_wr_gnt  (dma_wr_gnt),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .ub_buf_sel  (ub_buf_sel),
        .busy        (busy),
`ifdef UB_SCHED_STATS_EN
        .rd_conflict_cnt (rd_conflict_cnt),
        .wr_conflict_cnt (wr_conflict_cnt),
`endif
        .ub_rd_en    (ub_rd_en),
        .ub_rd_addr  (ub_rd_addr),
        .ub_rd_data  (ub_rd_data),
        .ub_wr_en    (ub_wr_en),
        .ub_wr_addr  (ub_wr_addr),
        .ub_wr_data  (ub_wr_data)
    );

    task automatic model_reset();
        m_buf_sel = 0; m_rd_fav_dma = 0; m_wr_fav_dma = 0;
        m_sys_inflight = 0; m_dma_inflight = 0;
        m_phase = 0; m_rd_cnt = 0; m_wr_cnt = 0;
    endtask

    task automatic model_eval();
        bit open;
        open         = (m_phase == 0);
        e_sys_gnt    = open && sys_rd_req && (!dma_rd_req || !m_rd_fav_dma);
        e_dma_rd_gnt = open && dma_rd_req && (!sys_rd_req || m_rd_fav_dma);
        e_vpu_gnt    = open && vpu_wr_req && (!dma_wr_req || !m_wr_fav_dma);
        e_dma_wr_gnt = open && dma_wr_req && (!vpu_wr_req || m_wr_fav_dma);
        e_rd_addr = 9'h000;
        if (e_sys_gnt) e_rd_addr = {m_buf_sel, sys_rd_addr};
        else if (e_dma_rd_gnt) e_rd_addr = dma_rd_addr;
        e_wr_addr = 9'h000;
        e_wr_data = 64'h0;
        if (e_vpu_gnt) begin
            e_wr_addr = {!m_buf_sel, vpu_wr_addr};
            e_wr_data = vpu_wr_data;
        end else if (e_dma_wr_gnt) begin
            e_wr_addr = dma_wr_addr;
            e_wr_data = dma_wr_data;
        end
    endtask

    task automatic model_commit();
        if (m_phase == 0 && sys_rd_req && dma_rd_req) m_rd_fav_dma = e_sys_gnt;
        if (m_phase == 0 && vpu_wr_req && dma_wr_req) m_wr_fav_dma = e_vpu_gnt;
        if (sys_rd_req && dma_rd_req && m_rd_cnt < 65535) m_rd_cnt++;
        if (vpu_wr_req && dma_wr_req && m_wr_cnt < 65535) m_wr_cnt++;
        case (m_phase)
            0: if (swap_req) m_phase = 1;
            1: if (!m_sys_inflight && !m_dma_inflight) m_phase = 2;
            default: begin m_buf_sel = !m_buf_sel; m_phase = 0; end
        endcase
        m_sys_inflight = e_sys_gnt;
        m_dma_inflight = e_dma_rd_gnt;
    endtask

    // Advance one clock, keeping the model in step; returns at posedge+1.
    task automatic step();
        @(posedge clk);
        model_eval();
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        sys_rd_req = 0; dma_rd_req = 0; vpu_wr_req = 0; dma_wr_req = 0; swap_req = 0;
        sys_rd_addr = '0; vpu_wr_addr = '0; dma_rd_addr = '0; dma_wr_addr = '0;
        vpu_wr_data = '0; dma_wr_data = '0; ub_rd_data = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        sys_rd_req = 1; vpu_wr_req = 1;
        repeat (2) @(posedge clk);
        #4;
        checks++;
        if ({sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt, dma_wr_gnt, sys_rd_vld, dma_rd_vld,
             swap_ack, ub_buf_sel, busy, ub_rd_en, ub_wr_en} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b required 0", {sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt,
                     dma_wr_gnt, sys_rd_vld, dma_rd_vld, swap_ack, ub_buf_sel, busy, ub_rd_en, ub_wr_en});
        end
        checks++;
        if ({ub_rd_addr, ub_wr_addr, ub_wr_data} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_addr_data: got rd=%h wr=%h data=%h required 0", ub_rd_addr, ub_wr_addr, ub_wr_data);
        end
        @(posedge clk);
        #1 rst = 0;
        clear_inputs();
        model_reset();
    endtask

    task automatic test_sys_read();
        logic [63:0] d;
        sys_rd_req = 1; sys_rd_addr = 8'h20;
        #3;
        checks++;
        if (sys_rd_gnt !== 1'b1 || ub_rd_en !== 1'b1 || ub_rd_addr !== 9'h020) begin
            failures++;
            $display("[TB] FAIL sys_rd_grant: got gnt=%b en=%b addr=%h required 1 1 020", sys_rd_gnt, ub_rd_en, ub_rd_addr);
        end
        step();
        sys_rd_req = 0;
        d = {$urandom, $urandom};
        ub_rd_data = d;
        #3;
        checks++;
        if (sys_rd_vld !== 1'b1 || dma_rd_vld !== 1'b0 || rd_data !== d) begin
            failures++;
            $display("[TB] FAIL sys_rd_vld: got vld=%b dvld=%b data=%h required 1 0 %h", sys_rd_vld, dma_rd_vld, rd_data, d);
        end
        step();
    endtask

    task automatic test_vpu_write();
        logic [63:0] d;
        d = {$urandom, $urandom};
        vpu_wr_req = 1; vpu_wr_addr = 8'h40; vpu_wr_data = d;
        #3;
        checks++;
        if (vpu_wr_gnt !== 1'b1 || ub_wr_en !== 1'b1 || ub_wr_addr !== 9'h140 || ub_wr_data !== d) begin
            failures++;
            $display("[TB] FAIL vpu_write: got gnt=%b en=%b addr=%h data=%h required 1 1 140 %h",
                     vpu_wr_gnt, ub_wr_en, ub_wr_addr, ub_wr_data, d);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_rd_round_robin();
        do_reset();
        sys_rd_req = 1; dma_rd_req = 1;
        sys_rd_addr = 8'h11; dma_rd_addr = 9'h1AB;
        for (int i = 0; i < 4; i++) begin
            #3;
            checks++;
            if ({sys_rd_gnt, dma_rd_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("[TB] FAIL rd_rr_%0d: got sys/dma=%b%b required %b", i, sys_rd_gnt, dma_rd_gnt,
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
        end
        clear_inputs();
`ifdef UB_SCHED_STATS_EN
        #3;
        checks++;
        if (rd_conflict_cnt !== 16'd4) begin
            failures++;
            $display("[TB] FAIL rd_conflict_cnt: got %0d required 4", rd_conflict_cnt);
        end
`endif
        step();
    endtask

    task automatic test_swap_inflight();
        do_reset();
        sys_rd_req = 1; sys_rd_addr = 8'h33; swap_req = 1;
        #3;
        checks++;
        if (sys_rd_gnt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL swap_same_cycle_gnt: got %b required 1", sys_rd_gnt);
        end
        step();
        swap_req = 0; dma_rd_req = 1; vpu_wr_req = 1; dma_wr_req = 1;
        for (int c = 1; c <= 3; c++) begin
            #3;
            checks++;
            if ({sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt, dma_wr_gnt} !== 4'b0 || swap_ack !== (c == 3)
                || busy !== 1'b1 || sys_rd_vld !== (c == 1) || ub_buf_sel !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drain_cycle_%0d: got gnts=%b ack=%b busy=%b vld=%b sel=%b", c,
                         {sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt, dma_wr_gnt}, swap_ack, busy, sys_rd_vld, ub_buf_sel);
            end
            step();
        end
        dma_rd_req = 0; dma_wr_req = 0;
        sys_rd_addr = 8'h60; vpu_wr_addr = 8'h60;
        #3;
        checks++;
        if (ub_buf_sel !== 1'b1 || ub_rd_addr !== 9'h160 || ub_wr_addr !== 9'h060 || sys_rd_gnt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_swap_map: got sel=%b rd=%h wr=%h gnt=%b required 1 160 060 1",
                     ub_buf_sel, ub_rd_addr, ub_wr_addr, sys_rd_gnt);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_in_drain();
        sys_rd_req = 1; sys_rd_addr = 8'h05; swap_req = 1;
        step();
        swap_req = 0; dma_rd_req = 1; vpu_wr_req = 1; dma_wr_req = 1;
        #3;
        checks++;
        if (sys_rd_vld !== 1'b1 || busy !== 1'b1 || ub_buf_sel !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_setup: got vld=%b busy=%b sel=%b required 1 1 1", sys_rd_vld, busy, ub_buf_sel);
        end
        rst = 1;
        #1;
        checks++;
        if ({sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt, dma_wr_gnt, sys_rd_vld, dma_rd_vld,
             swap_ack, ub_buf_sel, busy, ub_rd_en, ub_wr_en} !== 11'b0
            || {ub_rd_addr, ub_wr_addr, ub_wr_data} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: got ctrl=%b rd=%h wr=%h required all 0", {sys_rd_gnt, dma_rd_gnt,
                     vpu_wr_gnt, dma_wr_gnt, sys_rd_vld, dma_rd_vld, swap_ack, ub_buf_sel, busy, ub_rd_en, ub_wr_en},
                     ub_rd_addr, ub_wr_addr);
        end
        @(posedge clk);
        #1 rst = 0;
        clear_inputs();
        model_reset();
        #3;
        checks++;
        if (busy !== 1'b0 || sys_rd_vld !== 1'b0 || ub_buf_sel !== 1'b0 || swap_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_reset: got busy=%b vld=%b sel=%b ack=%b required 0", busy, sys_rd_vld, ub_buf_sel, swap_ack);
        end
        step();
    endtask

    task automatic test_swap_ignored();
        int acks;
        acks = 0;
        do_reset();
        swap_req = 1;
        step();
        for (int c = 0; c < 8; c++) begin
            swap_req = (c == 0);
            #3;
            if (swap_ack === 1'b1) acks++;
            step();
        end
        swap_req = 0;
        #3;
        checks++;
        if (acks != 1 || ub_buf_sel !== 1'b1) begin
            failures++;
            $display("[TB] FAIL swap_once: got acks=%0d sel=%b required 1 1", acks, ub_buf_sel);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sys_rd_req  = $urandom_range(0, 1);
            dma_rd_req  = $urandom_range(0, 1);
            vpu_wr_req  = $urandom_range(0, 1);
            dma_wr_req  = $urandom_range(0, 1);
            swap_req    = ($urandom_range(0, 11) == 0);
            sys_rd_addr = 8'($urandom);
            vpu_wr_addr = 8'($urandom);
            dma_rd_addr = 9'($urandom);
            dma_wr_addr = 9'($urandom);
            vpu_wr_data = {$urandom, $urandom};
            dma_wr_data = {$urandom, $urandom};
            ub_rd_data  = {$urandom, $urandom};
            #3;
            model_eval();
            checks++;
            if ({sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt, dma_wr_gnt} !== {e_sys_gnt, e_dma_rd_gnt, e_vpu_gnt, e_dma_wr_gnt}) begin
                failures++;
                $display("[TB] FAIL rand_gnt[%0d]: got %b required %b", i, {sys_rd_gnt, dma_rd_gnt, vpu_wr_gnt, dma_wr_gnt},
                         {e_sys_gnt, e_dma_rd_gnt, e_vpu_gnt, e_dma_wr_gnt});
            end
            checks++;
            if ({sys_rd_vld, dma_rd_vld} !== {m_sys_inflight, m_dma_inflight} || rd_data !== ub_rd_data) begin
                failures++;
                $display("[TB] FAIL rand_vld[%0d]: got %b required %b", i, {sys_rd_vld, dma_rd_vld}, {m_sys_inflight, m_dma_inflight});
            end
            checks++;
            if (ub_rd_en !== (e_sys_gnt || e_dma_rd_gnt) || ub_rd_addr !== e_rd_addr) begin
                failures++;
                $display("[TB] FAIL rand_rd_port[%0d]: got en=%b addr=%h required addr %h", i, ub_rd_en, ub_rd_addr, e_rd_addr);
            end
            checks++;
            if (ub_wr_en !== (e_vpu_gnt || e_dma_wr_gnt) || ub_wr_addr !== e_wr_addr || ub_wr_data !== e_wr_data) begin
                failures++;
                $display("[TB] FAIL rand_wr_port[%0d]: got en=%b addr=%h data=%h required addr %h data %h",
                         i, ub_wr_en, ub_wr_addr, ub_wr_data, e_wr_addr, e_wr_data);
            end
            checks++;
            if (swap_ack !== (m_phase == 2) || ub_buf_sel !== m_buf_sel
                || busy !== (m_phase != 0 || m_sys_inflight || m_dma_inflight)) begin
                failures++;
                $display("[TB] FAIL rand_swap[%0d]: got ack=%b sel=%b busy=%b required phase %0d sel %b",
                         i, swap_ack, ub_buf_sel, busy, m_phase, m_buf_sel);
            end
`ifdef UB_SCHED_STATS_EN
            checks++;
            if (rd_conflict_cnt !== 16'(m_rd_cnt) || wr_conflict_cnt !== 16'(m_wr_cnt)) begin
                failures++;
                $display("[TB] FAIL rand_stats[%0d]: got rd=%0d wr=%0d required %0d %0d",
                         i, rd_conflict_cnt, wr_conflict_cnt, m_rd_cnt, m_wr_cnt);
            end
`endif
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_sys_read();
        test_vpu_write();
        test_rd_round_robin();
        test_swap_inflight();
        test_reset_in_drain();
        test_swap_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
